// File: rtl/zipo_mem_ctrl.sv
// ---------------------------------------------------------------------------
// zipo_mem_ctrl
//
// Memory controller between the zipocpu bus master and on-chip word storage.
// An accepted request is latched, held for WAIT_STATES extra cycles and then
// completed with a one-cycle cpu_ready pulse. Word addresses outside
// 0..MEM_WORDS-1 (other than the LED register) complete with exception set,
// no side effects and zero read data. One memory-mapped LED register lives at
// LED_ADDR.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   cpu_req    access request, held by the CPU until cpu_ready
//   cpu_rw     1 = write, 0 = read
//   cpu_addr   word address (ADDR_W bits)
//   cpu_wdata  write data (DATA_W bits)
//   cpu_rdata  read data, held until the next completed read or error
//   cpu_ready  one-cycle completion pulse
//   exception  one-cycle bad-address pulse, coincident with cpu_ready
//   led        LED register
// ---------------------------------------------------------------------------
module zipo_mem_ctrl #(
    parameter int                 ADDR_W      = 64,
    parameter int                 DATA_W      = 64,
    parameter int                 MEM_WORDS   = 256,
    parameter int                 WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0]  LED_ADDR    = 64'hFFFF_FFFF_FFFF_FFF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              exception,
    output logic [7:0]        led
);

    localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE,
        ERR
    } state_t;

    state_t              state;
    logic [3:0]          wait_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                rw_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                bad_q;

    logic [DATA_W-1:0]   mem [MEM_WORDS];

    // Full-width unsigned compare: addresses above MEM_WORDS never alias
    // onto storage through their low bits.
    logic                addr_ok;
    logic                is_led;
    logic [MEM_AW-1:0]   mem_idx;

    assign addr_ok = (cpu_addr == LED_ADDR) || (cpu_addr < ADDR_W'(MEM_WORDS));
    assign is_led  = (addr_q == LED_ADDR);
    assign mem_idx = addr_q[MEM_AW-1:0];

    // NOTE: storage arrays carry no reset; clearing them would force a
    // flop-based implementation instead of RAM. Reset still blocks writes
    // because it forces the FSM out of DONE.
    always_ff @(posedge clk) begin
        if (state == DONE && rw_q && !is_led) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            bad_q     <= 1'b0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            exception <= 1'b0;
            led       <= '0;
        end else begin
            // Status pulses last exactly one cycle.
            cpu_ready <= 1'b0;
            exception <= 1'b0;

            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        rw_q    <= cpu_rw;
                        wdata_q <= cpu_wdata;
                        bad_q   <= !addr_ok;
                        if (WAIT_STATES == 0) begin
                            state <= addr_ok ? DONE : ERR;
                        end else begin
                            wait_cnt <= 4'(WAIT_STATES);
                            state    <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= bad_q ? ERR : DONE;
                    end
                end

                DONE: begin
                    if (rw_q) begin
                        if (is_led) begin
                            led <= wdata_q[7:0];
                        end
                    end else begin
                        cpu_rdata <= is_led ? {{(DATA_W-8){1'b0}}, led}
                                            : mem[mem_idx];
                    end
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end

                ERR: begin
                    cpu_rdata <= '0;
                    cpu_ready <= 1'b1;
                    exception <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/zipo_mem_ctrl.md
Name: zipo_mem_ctrl

Overview:
Memory controller between the zipocpu bus master and on-chip word storage. It replaces the bare RAM model with a request/ready handshake and a configurable number of wait states. It checks addresses against the memory size and raises an exception on out-of-range access. It also decodes one memory-mapped LED register.

Parameters:
ADDR_W, 64, CPU address width.
DATA_W, 64, data word width.
MEM_WORDS, 256, number of DATA_W words of storage; valid word addresses are 0..MEM_WORDS-1.
WAIT_STATES, 2, extra cycles before completion (0..15).
LED_ADDR, 64'hFFFF_FFFF_FFFF_FFF0, word address of the LED register.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
cpu_req  in  1  access request; held high by the CPU until cpu_ready.
cpu_rw  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_W  word address.
cpu_wdata  in  DATA_W  write data.
cpu_rdata  out  DATA_W  read data.
cpu_ready  out  1  one-cycle completion pulse.
exception  out  1  one-cycle bad-address pulse, coincident with cpu_ready.
led  out  8  LED register.

Behaviour:
- Clocking and reset: one clock, clk; rst is asynchronous and active-high.
- Reset values: state IDLE, cpu_ready 0, exception 0, cpu_rdata 0, led 0, wait counter 0. Memory contents are not reset.
- FSM states: IDLE, WAIT, DONE, ERR.
- IDLE:
  - cpu_req is sampled only in IDLE.
  - At a rising edge with cpu_req=1, latch addr, rw and wdata.
  - If addr == LED_ADDR or addr < MEM_WORDS: go to WAIT with counter = WAIT_STATES, or straight to DONE when WAIT_STATES = 0.
  - Otherwise go to ERR after the same wait count.
  - The range comparison is full-width unsigned on all ADDR_W bits; no aliasing.
- WAIT: counter decrements each edge. On the edge where the counter is 1, go to DONE (or ERR if the address was flagged bad).
- Latency: a request sampled at edge E completes at edge E+WAIT_STATES+1. cpu_ready is high for exactly the following cycle.
- DONE edge actions:
  - Write: mem[addr] <= wdata, or led <= wdata[7:0] for LED_ADDR.
  - Read: cpu_rdata <= mem[addr], or {56'b0, led} for LED_ADDR.
  - Set cpu_ready = 1, then return to IDLE on the next edge.
- ERR edge actions:
  - No memory or LED update.
  - Set cpu_rdata = 0, cpu_ready = 1 and exception = 1, both for one cycle; then IDLE.
- Data holding:
  - cpu_rdata holds its value until the next completed read or error.
  - Writes do not change cpu_rdata.
- Request handling:
  - cpu_req changes while busy are ignored. Latched addr, rw and wdata are used, not live inputs.
  - If cpu_req is still high during the cpu_ready cycle, it is sampled again in the following IDLE cycle as a new request. Minimum spacing between accepted requests is WAIT_STATES+2 cycles.
- Read-after-write to the same address returns the new data.
- Reset mid-access: the access is abandoned, no write occurs, and no ready or exception is produced.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> cpu_ready, exception, cpu_rdata and led are all 0 immediately; FSM is in IDLE.
2. Write then read, WAIT_STATES=2:
   - Write addr 5, data 64'hDEAD_BEEF_0123_4567 sampled at edge 1 -> cpu_ready high only after edge 4.
   - Read addr 5 -> cpu_rdata = 64'hDEAD_BEEF_0123_4567 with cpu_ready after edge 4 of that access; exception stays 0.
3. LED: write LED_ADDR with data 64'h1B6 -> led = 8'hB6. Read LED_ADDR -> cpu_rdata = 64'h0000_0000_0000_00B6.
4. Out of range: write addr 256 (MEM_WORDS=256), data 64'h1 -> cpu_ready and exception high together for one cycle, cpu_rdata = 0. A subsequent read of addr 0 returns its prior value, confirming no wrap-around write.
5. Held request: hold cpu_req high continuously reading addr 3 -> ready pulses every 4 cycles (WAIT_STATES+2); changing cpu_addr to 7 mid-access does not affect the in-flight result.
6. Reset mid-write: assert rst one cycle before the expected DONE of a write to addr 9 (value 64'hAA) -> no cpu_ready, and mem[9] is unchanged when read back after reset.
